// File: rtl/alarm_controller.sv
// alarm_controller: alarm time register, minute-match trigger and ring/snooze FSM; optional snooze via ALARM_SNOOZE_EN
module alarm_controller #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int TW          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic [21:0] time_count,
  input  logic        alarm_set_en,
  input  logic [1:0]  adj_sel,
  input  logic        adj_inc,
  input  logic        alarm_arm,
  input  logic        stop,
  input  logic        snooze,
  output logic [21:0] alarm_count,
  output logic        armed,
  output logic        ringing,
  output logic        buzzer,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, RINGING = 2'b10, SNOOZE = 2'b11} state_t;
  state_t state_q, state_d;
  logic [1:0] hrt_q, hrt_d;
  logic [3:0] hro_q, hro_d, mint_q, mint_d, mino_q, mino_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic beep_q, beep_d, match_q, match, trigger, snz, inc_min, inc_hr, wrap23;
  assign alarm_count = {hrt_q, hro_q, mint_q, mino_q, 8'h00};
  assign match   = (time_count[21:8] == alarm_count[21:8]) && (time_count[7:0] == 8'h00) && !alarm_set_en;
  assign trigger = match & ~match_q;
`ifdef ALARM_SNOOZE_EN
  assign snz = snooze;
`else
  assign snz = snooze & 1'b0;
`endif
  assign inc_min = alarm_set_en && adj_inc && (adj_sel == 2'b01);
  assign inc_hr  = alarm_set_en && adj_inc && (adj_sel == 2'b10);
  assign wrap23  = (hrt_q == 2'd2) && (hro_q == 4'd3);
  assign state   = state_q;
  assign armed   = state_q != IDLE;
  assign ringing = state_q == RINGING;
  assign buzzer  = ringing & beep_q;
  // BCD increment of the selected alarm field; minutes never carry into hours
  always_comb begin
    mino_d = inc_min ? ((mino_q == 4'd9) ? 4'd0 : mino_q + 4'd1) : mino_q;
    mint_d = (inc_min && mino_q == 4'd9) ? ((mint_q == 4'd5) ? 4'd0 : mint_q + 4'd1) : mint_q;
    hro_d  = inc_hr ? ((wrap23 || hro_q == 4'd9) ? 4'd0 : hro_q + 4'd1) : hro_q;
    hrt_d  = inc_hr ? (wrap23 ? 2'd0 : (hro_q == 4'd9) ? hrt_q + 2'd1 : hrt_q) : hrt_q;
  end
  // ring/snooze sequencing with a shared down-counter for both timeouts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beep_d  = beep_q;
    if (!alarm_arm) state_d = IDLE;
    else
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED:
          if (trigger) begin
            state_d = RINGING;
            cnt_d   = TW'(RING_SECS);
            beep_d  = 1'b1;
          end
        RINGING:
          if (stop) state_d = ARMED;
          else if (snz) begin
            state_d = SNOOZE;
            cnt_d   = TW'(SNOOZE_SECS);
          end else if (tick_1hz) begin
            cnt_d   = cnt_q - TW'(1);
            beep_d  = ~beep_q;
            state_d = (cnt_q == TW'(1)) ? ARMED : RINGING;
          end
        default:
`ifdef ALARM_SNOOZE_EN
          if (stop) state_d = ARMED;
          else if (tick_1hz) begin
            state_d = (cnt_q == TW'(1)) ? RINGING : SNOOZE;
            cnt_d   = (cnt_q == TW'(1)) ? TW'(RING_SECS) : cnt_q - TW'(1);
            beep_d  = (cnt_q == TW'(1)) ? 1'b1 : beep_q;
          end
`else
          state_d = IDLE;
`endif
      endcase
  end
  // state, alarm time and match history registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beep_q  <= 1'b0;
      match_q <= 1'b0;
      hrt_q   <= '0;
      hro_q   <= '0;
      mint_q  <= '0;
      mino_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beep_q  <= beep_d;
      match_q <= match;
      hrt_q   <= hrt_d;
      hro_q   <= hro_d;
      mint_q  <= mint_d;
      mino_q  <= mino_d;
    end
  end
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed plus random stimulus against an integer-time reference model
module tb_alarm_controller;
  logic clk = 0, rst = 0, tick_1hz = 0, alarm_set_en = 0, adj_inc = 0, alarm_arm = 0, stop = 0, snooze = 0;
  logic [1:0] adj_sel = 0;
  int th = 0, tm = 0, ts = 0;
  logic [21:0] time_count, alarm_count;
  logic armed, ringing, buzzer;
  logic [1:0] state;
  int checks = 0, errors = 0;
  int m_hr, m_min, m_st, m_rem;
  bit m_prev;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1;
`else
  localparam bit SNZ = 0;
`endif

  always #5 clk = ~clk;

  function automatic logic [21:0] bcd(int h, int m, int s);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  assign time_count = bcd(th, tm, ts);

  alarm_controller dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .time_count(time_count),
    .alarm_set_en(alarm_set_en), .adj_sel(adj_sel), .adj_inc(adj_inc),
    .alarm_arm(alarm_arm), .stop(stop), .snooze(snooze),
    .alarm_count(alarm_count), .armed(armed), .ringing(ringing),
    .buzzer(buzzer), .state(state)
  );

  task automatic chk(string tag, logic [21:0] obs, logic [21:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset;
    m_hr = 0; m_min = 0; m_st = 0; m_rem = 0; m_prev = 0;
  endtask

  task automatic expect_all(string tag);
    chk({tag, " state"}, 22'(state), 22'(m_st));
    chk({tag, " armed"}, 22'(armed), 22'(m_st != 0));
    chk({tag, " ringing"}, 22'(ringing), 22'(m_st == 2));
    chk({tag, " buzzer"}, 22'(buzzer), 22'(m_st == 2 && ((60 - m_rem) % 2 == 0)));
    chk({tag, " alarm_count"}, alarm_count, bcd(m_hr, m_min, 0));
  endtask

  task automatic model_step;
    bit match, trig;
    match  = (th == m_hr) && (tm == m_min) && (ts == 0) && !alarm_set_en;
    trig   = match && !m_prev;
    m_prev = match;
    if (alarm_set_en && adj_inc) begin
      if (adj_sel == 2'd1) m_min = (m_min + 1) % 60;
      else if (adj_sel == 2'd2) m_hr = (m_hr + 1) % 24;
    end
    if (!alarm_arm) m_st = 0;
    else if (m_st == 0) m_st = 1;
    else if (m_st == 1) begin
      if (trig) begin m_st = 2; m_rem = 60; end
    end else if (m_st == 2) begin
      if (stop) m_st = 1;
      else if (snooze && SNZ) begin m_st = 3; m_rem = 300; end
      else if (tick_1hz) begin m_rem--; if (m_rem == 0) m_st = 1; end
    end else begin
      if (stop) m_st = 1;
      else if (tick_1hz) begin m_rem--; if (m_rem == 0) begin m_st = 2; m_rem = 60; end end
    end
  endtask

  task automatic cyc(string tag);
    model_step;
    @(posedge clk);
    #1;
    expect_all(tag);
    tick_1hz = 0; adj_inc = 0; stop = 0; snooze = 0;
  endtask

  task automatic ring_up;
    th = m_hr; tm = m_min; ts = 1;
    cyc("pre_match");
    ts = 0;
    cyc("match");
  endtask

  initial begin
    mreset;
    @(posedge clk); #1;
    expect_all("reset_hold");
    rst = 1;
    alarm_set_en = 1; adj_sel = 2;
    repeat (25) begin adj_inc = 1; cyc("adj_hr"); end
    chk("hr_wrap", alarm_count, bcd(1, 0, 0));
    adj_sel = 1;
    repeat (61) begin adj_inc = 1; cyc("adj_min"); end
    chk("min_wrap", alarm_count, bcd(1, 1, 0));
    repeat (20) begin
      if ($urandom_range(0, 1) == 0) begin alarm_set_en = 0; adj_sel = 2'($urandom_range(0, 3)); end
      else begin alarm_set_en = 1; adj_sel = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3; end
      adj_inc = 1;
      cyc("adj_ignored");
    end
    chk("adj_ignored_hold", alarm_count, bcd(1, 1, 0));
    alarm_set_en = 1; adj_sel = 2;
    repeat (6) begin adj_inc = 1; cyc("set_hr"); end
    adj_sel = 1;
    repeat (29) begin adj_inc = 1; cyc("set_min"); end
    alarm_set_en = 0; adj_sel = 0;
    chk("alarm_0730", alarm_count, bcd(7, 30, 0));
    th = 7; tm = 29; ts = 59; alarm_arm = 1;
    cyc("arm");
    chk("armed_state", 22'(state), 22'd1);
    cyc("pre_match_0729");
    th = 7; tm = 30; ts = 0;
    cyc("match_0730");
    chk("ring_latency", 22'(ringing), 22'd1);
    stop = 1;
    cyc("stop");
    repeat (5) cyc("hold_no_retrigger");
    chk("no_retrigger", 22'(state), 22'd1);
    ring_up;
    for (int k = 1; k <= 60; k++) begin
      repeat ($urandom_range(0, 2)) cyc("ring_idle");
      tick_1hz = 1;
      cyc("ring_tick");
      chk("buzz_phase", 22'(buzzer), 22'(k < 60 && k % 2 == 0));
    end
    chk("ring_timeout", 22'(state), 22'd1);
    ring_up;
    snooze = 1;
    cyc("snooze");
`ifdef ALARM_SNOOZE_EN
    chk("snooze_state", 22'(state), 22'd3);
    for (int k = 1; k <= 300; k++) begin
      repeat ($urandom_range(0, 1)) cyc("snooze_idle");
      tick_1hz = 1;
      cyc("snooze_tick");
    end
    chk("snooze_expire", 22'(state), 22'd2);
    stop = 1; snooze = 1;
    cyc("stop_beats_snooze");
    chk("stop_priority", 22'(state), 22'd1);
`else
    chk("snooze_ignored", 22'(state), 22'd2);
    stop = 1;
    cyc("stop_no_snooze");
`endif
    ring_up;
    snooze = 1;
    cyc("snooze2");
    alarm_arm = 0;
    cyc("disarm");
    chk("disarm_idle", 22'(state), 22'd0);
    alarm_arm = 1;
    cyc("rearm");
    ts = 1;
    cyc("pre_set_en");
    alarm_set_en = 1; ts = 0;
    cyc("set_en_match");
    cyc("set_en_hold");
    chk("set_en_no_ring", 22'(ringing), 22'd0);
    ts = 5; alarm_set_en = 0;
    cyc("set_en_release");
    repeat (400) begin
      tick_1hz     = ($urandom_range(0, 3) == 0);
      stop         = ($urandom_range(0, 15) == 0);
      snooze       = ($urandom_range(0, 15) == 0);
      alarm_arm    = ($urandom_range(0, 31) != 0);
      alarm_set_en = ($urandom_range(0, 15) == 0);
      adj_inc      = ($urandom_range(0, 7) == 0);
      adj_sel      = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin th = $urandom_range(0, 23); tm = $urandom_range(0, 59); end
      else begin th = m_hr; tm = m_min; end
      ts = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 59);
      cyc("random");
    end
    alarm_arm = 1; alarm_set_en = 0; adj_sel = 0;
    stop = 1;
    cyc("settle");
    cyc("settle2");
    ring_up;
    chk("pre_reset_ring", 22'(ringing), 22'd1);
    #3 rst = 0;
    #1;
    mreset;
    expect_all("reset_mid_ring");
    @(posedge clk); #1;
    expect_all("reset_low_edge");
    rst = 1;
    cyc("post_reset");
    cyc("post_reset_armed");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
